// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// core_ctrl_pkg : shared types and inst field map for core_inst_ctrl
// Revision      : 1.0
// ============================================================================
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_QWR, S_KWR, S_KLOAD, S_KGAP,
        S_EXEC, S_DRAIN, S_ACC, S_DIV, S_RDOUT
    } state_t;

    localparam int INST_W = 19;
    localparam int CNT_W  = 5;

    localparam int INST_SFP_DIV  = 18;
    localparam int INST_SFP_ACC  = 17;
    localparam int INST_OFIFO_RD = 16;
    localparam int INST_EXECUTE  = 7;
    localparam int INST_KLOAD    = 6;
    localparam int INST_QMEM_RD  = 5;
    localparam int INST_QMEM_WR  = 4;
    localparam int INST_KMEM_RD  = 3;
    localparam int INST_KMEM_WR  = 2;
    localparam int INST_PMEM_RD  = 1;
    localparam int INST_PMEM_WR  = 0;

    localparam int QK_ADD_LSB   = 12;
    localparam int PMEM_ADD_LSB = 8;

    function automatic logic [INST_W-1:0] ibit(input int idx);
        return INST_W'(1) << idx;
    endfunction

    function automatic logic [INST_W-1:0] add_field(input logic [3:0] a, input int lsb);
        return INST_W'(a) << lsb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_cnt.sv
`default_nettype none
// ============================================================================
// phase_cnt : loadable 5-bit phase counter with clear and terminal-count flag
// Revision  : 1.0
// ============================================================================
module phase_cnt
    import core_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] term_val,
    output logic [3:0]       add,
    output logic             tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign add = r_cnt[3:0];
    assign tc  = (r_cnt == term_val);

endmodule
`default_nettype wire

// File: rtl/core_inst_ctrl.sv
`default_nettype none
// ============================================================================
// core_inst_ctrl : host Q/K intake and inst/mem_in sequencer for one core
// Revision       : 1.0
// ============================================================================
module core_inst_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int          col       = 8,
    parameter int          pr        = 8,
    parameter int          bw        = 8,
    parameter int          len       = 8,
    parameter int unsigned drain_cyc = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [pr*bw-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [INST_W-1:0]   inst,
    output logic [pr*bw-1:0]    mem_in,
    output logic                out_valid,
    output logic [3:0]          out_addr,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0] c_last_vec   = CNT_W'(len - 1);
    localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(drain_cyc - 1);
    localparam logic [3:0]       c_last_row   = 4'(len - 1);

    if (len < 1 || len > 16 || drain_cyc < 1 || col < 1) begin : g_bad_cfg
        $error("core_inst_ctrl: unsupported len/drain_cyc/col");
    end

    state_t           r_state;
    logic [3:0]       w_add;
    logic             w_tc;
    logic             w_hs;
    logic             w_cnt_inc;
    logic             w_cnt_clr;
    logic             w_step_done;
    logic [CNT_W-1:0] w_term;
    logic             w_last_row;

    phase_cnt u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_cnt_clr),
        .inc      (w_cnt_inc),
        .load     (1'b0),
        .load_val ('0),
        .term_val (w_term),
        .add      (w_add),
        .tc       (w_tc)
    );

    assign in_ready   = (r_state == S_QWR) || (r_state == S_KWR);
    assign w_last_row = inst[INST_PMEM_RD] && (inst[PMEM_ADD_LSB +: 4] == c_last_row);

    // Write phases only advance on a handshake; every other phase counts each cycle.
    always_comb begin
        w_hs        = in_ready & in_valid;
        w_term      = (r_state == S_DRAIN) ? c_drain_last : c_last_vec;
        w_cnt_inc   = 1'b1;
        w_step_done = w_tc;
        case (r_state)
            S_IDLE: begin
                w_cnt_inc   = 1'b0;
                w_step_done = start;
            end
            S_QWR, S_KWR: begin
                w_cnt_inc   = w_hs;
                w_step_done = w_hs & w_tc;
            end
            S_KGAP: begin
                w_cnt_inc   = 1'b0;
                w_step_done = 1'b1;
            end
            default: ;
        endcase
        w_cnt_clr = w_step_done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            inst      <= '0;
            mem_in    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inst      <= '0;
            out_valid <= inst[INST_PMEM_RD];
            out_addr  <= inst[PMEM_ADD_LSB +: 4];
            done      <= w_last_row;
            if (w_last_row) busy <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_QWR;
                    busy    <= 1'b1;
                end
                S_QWR: begin
                    if (w_hs) begin
                        inst   <= ibit(INST_QMEM_WR) | add_field(w_add, QK_ADD_LSB);
                        mem_in <= in_data;
                    end
                    if (w_step_done) r_state <= S_KWR;
                end
                S_KWR: begin
                    if (w_hs) begin
                        inst   <= ibit(INST_KMEM_WR) | add_field(w_add, QK_ADD_LSB);
                        mem_in <= in_data;
                    end
                    if (w_step_done) r_state <= S_KLOAD;
                end
                S_KLOAD: begin
                    inst <= ibit(INST_KMEM_RD) | ibit(INST_KLOAD) | add_field(w_add, QK_ADD_LSB);
                    if (w_step_done) r_state <= S_KGAP;
                end
                S_KGAP: r_state <= S_EXEC;
                S_EXEC: begin
                    inst <= ibit(INST_EXECUTE) | ibit(INST_QMEM_RD) | add_field(w_add, QK_ADD_LSB);
                    if (w_step_done) r_state <= S_DRAIN;
                end
                S_DRAIN: if (w_step_done) r_state <= S_ACC;
                S_ACC: begin
                    inst <= ibit(INST_SFP_ACC) | ibit(INST_OFIFO_RD);
                    if (w_step_done) r_state <= S_DIV;
                end
                S_DIV: begin
                    inst <= ibit(INST_SFP_DIV) | ibit(INST_PMEM_WR) | add_field(w_add, PMEM_ADD_LSB);
                    if (w_step_done) r_state <= S_RDOUT;
                end
                S_RDOUT: begin
                    inst <= ibit(INST_PMEM_RD) | add_field(w_add, PMEM_ADD_LSB);
                    if (w_step_done) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_inst_ctrl.sv
`default_nettype none
// ============================================================================
// tb_core_inst_ctrl : scoreboard bench for core_inst_ctrl at default sizes
// Revision          : 1.0
// ============================================================================
module tb_core_inst_ctrl;

    localparam int          PR      = 8;
    localparam int          BW      = 8;
    localparam int          LEN     = 8;
    localparam int          DRAIN   = 16;
    localparam int          RUN_CYC = 2*LEN + LEN + 1 + LEN + DRAIN + 3*LEN + 2;
    localparam logic [63:0] JUNK    = 64'hDEAD_BEEF_CAFE_F00D;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [PR*BW-1:0]  in_data  = '0;
    logic              in_ready;
    logic [18:0]       inst;
    logic [PR*BW-1:0]  mem_in;
    logic              out_valid;
    logic [3:0]        out_addr;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [63:0] data;
        logic [18:0] inst;
        logic        rdy;
        logic [63:0] mem;
        logic        ov;
        logic [3:0]  oa;
        logic        dn;
        logic        bz;
    } ent_t;

    ent_t        sb[$];
    logic [18:0] m_prev;
    logic        m_busy;
    logic [63:0] m_mem = '0;

    core_inst_ctrl #(
        .col       (8),
        .pr        (PR),
        .bw        (BW),
        .len       (LEN),
        .drain_cyc (DRAIN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .mem_in    (mem_in),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_inst"},      64'(inst),      64'd0);
        chk({tag, "_mem_in"},    64'(mem_in),    64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_addr"},  64'(out_addr),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
    endtask

    function automatic logic [63:0] qv(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {8{b}};
    endfunction

    function automatic logic [63:0] kv(input int k);
        logic [7:0] b;
        b = 8'(8'h80 + k);
        return {8{b}};
    endfunction

    // Expected outputs after the edge that samples this entry's inputs.
    task automatic push(input logic st, input logic v, input logic [63:0] d,
                        input logic [18:0] ei, input logic rdy, input logic wr);
        ent_t e;
        e.start = st;
        e.valid = v;
        e.data  = d;
        e.inst  = ei;
        e.rdy   = rdy;
        if (wr) m_mem = d;
        e.mem   = m_mem;
        e.ov    = m_prev[1];
        e.oa    = m_prev[11:8];
        e.dn    = m_prev[1] && (m_prev[11:8] == 4'(LEN - 1));
        if (e.dn) m_busy = 1'b0;
        e.bz    = m_busy;
        m_prev  = ei;
        sb.push_back(e);
    endtask

    task automatic build(input bit gap);
        m_prev = '0;
        m_busy = 1'b1;
        push(1, 1, JUNK, 19'h0, 1, 0);
        for (int k = 0; k < LEN; k++)
            push(0, 1, qv(k), 19'h00010 | (19'(k) << 12), 1, 1);
        for (int k = 0; k < LEN; k++) begin
            if (gap && k == 3)
                for (int g = 0; g < 3; g++) push(0, 0, JUNK, 19'h0, 1, 0);
            push(0, 1, kv(k), 19'h00004 | (19'(k) << 12), k != LEN - 1, 1);
        end
        for (int k = 0; k < LEN; k++) push(0, 1, JUNK, 19'h00048 | (19'(k) << 12), 0, 0);
        push(0, 1, JUNK, 19'h0, 0, 0);
        for (int k = 0; k < LEN; k++) push(k == 3, 1, JUNK, 19'h000A0 | (19'(k) << 12), 0, 0);
        for (int k = 0; k < DRAIN; k++) push(0, 1, JUNK, 19'h0, 0, 0);
        for (int k = 0; k < LEN; k++) push(0, 1, JUNK, 19'h30000, 0, 0);
        for (int k = 0; k < LEN; k++) push(0, 1, JUNK, 19'h40001 | (19'(k) << 8), 0, 0);
        for (int k = 0; k < LEN; k++) push(0, 0, JUNK, 19'h00002 | (19'(k) << 8), 0, 0);
        push(0, 0, JUNK, 19'h0, 0, 0);
        push(0, 0, JUNK, 19'h0, 0, 0);
    endtask

    task automatic run(input int cnt, output int done_at);
        ent_t e;
        done_at = -1;
        for (int n = 0; n < cnt && sb.size() > 0; n++) begin
            e = sb.pop_front();
            start    = e.start;
            in_valid = e.valid;
            in_data  = e.data;
            @(posedge clk);
            #1;
            chk($sformatf("inst@%0d", n),      64'(inst),      64'(e.inst));
            chk($sformatf("mem_in@%0d", n),    64'(mem_in),    e.mem);
            chk($sformatf("in_ready@%0d", n),  64'(in_ready),  64'(e.rdy));
            chk($sformatf("out_valid@%0d", n), 64'(out_valid), 64'(e.ov));
            chk($sformatf("out_addr@%0d", n),  64'(out_addr),  64'(e.oa));
            chk($sformatf("done@%0d", n),      64'(done),      64'(e.dn));
            chk($sformatf("busy@%0d", n),      64'(busy),      64'(e.bz));
            if (done === 1'b1 && done_at < 0) done_at = n + 1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int da;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        start = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        build(0);
        run(sb.size(), da);
        chk("run_len", 64'(da), 64'(RUN_CYC));

        build(1);
        run(sb.size(), da);
        chk("run_len_gap", 64'(da), 64'(RUN_CYC + 3));

        // Abort after ACC row 3 has been issued, away from any clock edge.
        build(0);
        run(2*LEN + LEN + 1 + LEN + DRAIN + 4 + 1, da);
        sb.delete();
        #2 reset = 1'b0;
        #1 chk_zero("async_reset");
        m_mem = '0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        build(0);
        run(sb.size(), da);
        chk("run_len_restart", 64'(da), 64'(RUN_CYC));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
